// File: rtl/alu_result_stage.sv
// ALU result stage: one-entry output register with NZVC flag commit,
// branch resolution (CBZ/CBNZ/B.cond) and a taken-branch counter.
module alu_result_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] alu_result,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        alu_c,
    input  logic        set_flags,
    input  logic        reg_write,
    input  logic [4:0]  rd,
    input  logic [1:0]  br_type,
    input  logic [3:0]  cond,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_br_taken,
    output logic [3:0]  flags,
    output logic [15:0] taken_cnt
);
    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  rd;
        logic        reg_write;
        logic        br_taken;
    } entry_t;

    entry_t entry_q;
    logic   valid_q;
    logic   accept;
    logic   cond_true;
    logic   taken;
    logic   fn, fz, fv, fc;

    assign {fn, fz, fv, fc} = flags;

    // B.cond looks at the committed flags, never at this transaction's own update
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'b0000: cond_true = fz;
            4'b0001: cond_true = !fz;
            4'b0010: cond_true = fc;
            4'b0011: cond_true = !fc;
            4'b0100: cond_true = fn;
            4'b0101: cond_true = !fn;
            4'b0110: cond_true = fv;
            4'b0111: cond_true = !fv;
            4'b1000: cond_true = fc & !fz;
            4'b1001: cond_true = !fc | fz;
            4'b1010: cond_true = (fn == fv);
            4'b1011: cond_true = (fn != fv);
            4'b1100: cond_true = !fz & (fn == fv);
            4'b1101: cond_true = fz | (fn != fv);
            default: cond_true = 1'b1;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (br_type)
            2'b01:   taken = alu_z;
            2'b10:   taken = !alu_z;
            2'b11:   taken = cond_true;
            default: taken = 1'b0;
        endcase
    end

    assign in_ready = !valid_q | out_ready;
    assign accept   = in_valid & in_ready & !flush;

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            entry_q   <= '0;
            flags     <= 4'b0000;
            taken_cnt <= 16'h0000;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q            <= 1'b1;
            entry_q.result     <= alu_result;
            entry_q.rd         <= rd;
            entry_q.reg_write  <= reg_write;
            entry_q.br_taken   <= taken;
            if (set_flags) flags <= {alu_n, alu_z, alu_v, alu_c};
            if (taken) taken_cnt <= taken_cnt + 16'h0001;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid     = valid_q;
    assign out_result    = entry_q.result;
    assign out_rd        = entry_q.rd;
    assign out_reg_write = entry_q.reg_write;
    assign out_br_taken  = entry_q.br_taken;
endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed table, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_alu_result_stage;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready;
    logic [63:0] alu_result;
    logic        alu_n, alu_z, alu_v, alu_c;
    logic        set_flags, reg_write;
    logic [4:0]  rd;
    logic [1:0]  br_type;
    logic [3:0]  cond;
    logic        flush, out_valid, out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_br_taken;
    logic [3:0]  flags;
    logic [15:0] taken_cnt;

    int nvec = 0;
    int nerr = 0;

    // reference model state
    bit          m_valid;
    logic [63:0] m_result;
    logic [4:0]  m_rd;
    bit          m_rw, m_taken;
    logic [3:0]  m_flags;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
        .alu_c(alu_c), .set_flags(set_flags), .reg_write(reg_write), .rd(rd),
        .br_type(br_type), .cond(cond), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_br_taken(out_br_taken),
        .flags(flags), .taken_cnt(taken_cnt)
    );

    typedef struct {
        bit          iv;
        logic [63:0] res;
        bit          n, z, v, c, sf, rw;
        logic [4:0]  rdi;
        logic [1:0]  bt;
        logic [3:0]  cnd;
        bit          ordy;
        bit          e_valid;
        logic [63:0] e_res;
        logic [4:0]  e_rd;
        bit          e_taken;
        logic [3:0]  e_flags;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ARM condition semantics: pairs of codes share a base test, odd code inverts
    function automatic bit cond_holds(input logic [3:0] f, input logic [3:0] c);
        bit n, z, v, cc, r;
        n = f[3]; z = f[2]; v = f[1]; cc = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cc;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cc && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !r : r;
    endfunction

    task automatic model_step();
        bit t;
        if (!reset) begin
            m_valid = 0; m_result = '0; m_rd = '0; m_rw = 0; m_taken = 0;
            m_flags = '0; m_cnt = '0;
        end else if (flush) begin
            m_valid = 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            case (br_type)
                2'b01:   t = alu_z;
                2'b10:   t = !alu_z;
                2'b11:   t = cond_holds(m_flags, cond);
                default: t = 0;
            endcase
            m_valid = 1; m_result = alu_result; m_rd = rd; m_rw = reg_write; m_taken = t;
            if (set_flags) m_flags = {alu_n, alu_z, alu_v, alu_c};
            if (t) m_cnt = m_cnt + 16'd1;
        end else if (out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        @(posedge clk);
        model_step();
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            chk("out_result", out_result, m_result);
            chk("out_rd", 64'(out_rd), 64'(m_rd));
            chk("out_reg_write", 64'(out_reg_write), 64'(m_rw));
            chk("out_br_taken", 64'(out_br_taken), 64'(m_taken));
        end
        chk("flags", 64'(flags), 64'(m_flags));
        chk("taken_cnt", 64'(taken_cnt), 64'(m_cnt));
    endtask

    task automatic idle_inputs();
        in_valid = 0; alu_result = '0; alu_n = 0; alu_z = 0; alu_v = 0; alu_c = 0;
        set_flags = 0; reg_write = 0; rd = '0; br_type = 2'b00; cond = 4'b0000;
        flush = 0; out_ready = 1; reset = 1;
    endtask

    task automatic check_reset_state();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        chk("rst_out_reg_write", 64'(out_reg_write), 64'd0);
        chk("rst_out_br_taken", 64'(out_br_taken), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_taken_cnt", 64'(taken_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [3:0]  f_save;
        logic [15:0] c_save;
        int guard;

        // iv res n z v c sf rw rd bt cnd ordy | valid res rd taken flags cnt
        tbl[0]  = '{1, 64'h2A, 0,0,0,0, 0,1, 5'd5, 2'b00, 4'h0, 1,  1, 64'h2A, 5'd5, 0, 4'b0000, 16'd0};
        tbl[1]  = '{0, 64'h0,  0,0,0,0, 0,0, 5'd0, 2'b00, 4'h0, 1,  0, 64'h0,  5'd0, 0, 4'b0000, 16'd0};
        tbl[2]  = '{1, 64'h11, 1,0,0,0, 1,1, 5'd1, 2'b00, 4'h0, 1,  1, 64'h11, 5'd1, 0, 4'b1000, 16'd0};
        tbl[3]  = '{1, 64'h22, 0,0,0,0, 0,0, 5'd2, 2'b11, 4'hB, 1,  1, 64'h22, 5'd2, 1, 4'b1000, 16'd1};
        tbl[4]  = '{1, 64'h33, 0,0,0,0, 0,0, 5'd3, 2'b11, 4'hA, 1,  1, 64'h33, 5'd3, 0, 4'b1000, 16'd1};
        tbl[5]  = '{1, 64'h0,  0,1,0,0, 0,0, 5'd4, 2'b01, 4'h0, 1,  1, 64'h0,  5'd4, 1, 4'b1000, 16'd2};
        tbl[6]  = '{1, 64'h0,  0,1,0,0, 0,0, 5'd6, 2'b10, 4'h0, 1,  1, 64'h0,  5'd6, 0, 4'b1000, 16'd2};
        tbl[7]  = '{1, 64'h0,  0,1,0,1, 1,1, 5'd7, 2'b11, 4'h0, 1,  1, 64'h0,  5'd7, 0, 4'b0101, 16'd2};
        tbl[8]  = '{1, 64'h44, 0,0,0,0, 0,0, 5'd8, 2'b11, 4'h0, 1,  1, 64'h44, 5'd8, 1, 4'b0101, 16'd3};
        tbl[9]  = '{1, 64'h55, 0,0,0,0, 0,0, 5'd9, 2'b11, 4'h8, 1,  1, 64'h55, 5'd9, 0, 4'b0101, 16'd3};
        tbl[10] = '{1, 64'h66, 0,0,0,0, 0,1, 5'd10,2'b11, 4'hF, 1,  1, 64'h66, 5'd10,1, 4'b0101, 16'd4};
        tbl[11] = '{0, 64'h0,  0,0,0,0, 0,0, 5'd0, 2'b00, 4'h0, 1,  0, 64'h0,  5'd0, 0, 4'b0101, 16'd4};

        idle_inputs();
        reset = 0;
        m_valid = 0; m_result = '0; m_rd = '0; m_rw = 0; m_taken = 0; m_flags = '0; m_cnt = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset_state();
        reset = 1;

        // directed table
        for (int i = 0; i < 12; i++) begin
            in_valid = tbl[i].iv; alu_result = tbl[i].res;
            alu_n = tbl[i].n; alu_z = tbl[i].z; alu_v = tbl[i].v; alu_c = tbl[i].c;
            set_flags = tbl[i].sf; reg_write = tbl[i].rw; rd = tbl[i].rdi;
            br_type = tbl[i].bt; cond = tbl[i].cnd; out_ready = tbl[i].ordy;
            tick();
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_result", i), out_result, tbl[i].e_res);
                chk($sformatf("tbl%0d_rd", i), 64'(out_rd), 64'(tbl[i].e_rd));
                chk($sformatf("tbl%0d_taken", i), 64'(out_br_taken), 64'(tbl[i].e_taken));
            end
            chk($sformatf("tbl%0d_flags", i), 64'(flags), 64'(tbl[i].e_flags));
            chk($sformatf("tbl%0d_cnt", i), 64'(taken_cnt), 64'(tbl[i].e_cnt));
        end

        // backpressure: A held while B waits
        idle_inputs(); tick();
        in_valid = 1; alu_result = 64'hAAAA; rd = 5'd3; reg_write = 1; out_ready = 0;
        tick();
        alu_result = 64'hBBBB; rd = 5'd4;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_result", out_result, 64'hAAAA);
            chk("bp_hold_rd", 64'(out_rd), 64'd3);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1;
        tick();
        chk("bp_load_b", out_result, 64'hBBBB);
        chk("bp_valid_stays", 64'(out_valid), 64'd1);
        idle_inputs(); tick();

        // flush with an entry held and a flag-setting branch incoming
        in_valid = 1; alu_result = 64'h77; out_ready = 0;
        tick();
        f_save = m_flags; c_save = m_cnt;
        flush = 1; set_flags = 1; alu_n = 0; alu_z = 1; alu_v = 1; alu_c = 0; br_type = 2'b01;
        tick();
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_flags", 64'(flags), 64'(f_save));
        chk("flush_cnt", 64'(taken_cnt), 64'(c_save));
        idle_inputs(); tick();

        // counter wrap through a long run of taken CBZs
        in_valid = 1; br_type = 2'b01; alu_z = 1; out_ready = 1;
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            tick();
            guard++;
        end
        chk("cnt_preload", 64'(taken_cnt), 64'hFFFF);
        tick();
        chk("cnt_wrap", 64'(taken_cnt), 64'h0);
        idle_inputs(); tick();

        // reset mid-transaction beats flush and accept
        in_valid = 1; alu_result = 64'h99; rd = 5'd9; reg_write = 1; out_ready = 0;
        set_flags = 1; alu_n = 1; br_type = 2'b01; alu_z = 1;
        tick();
        reset = 0; flush = 1;
        tick();
        check_reset_state();
        idle_inputs(); tick();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            in_valid   = $urandom_range(3) != 0;
            alu_result = {$urandom, $urandom};
            {alu_n, alu_z, alu_v, alu_c} = 4'($urandom);
            set_flags  = $urandom_range(1);
            reg_write  = $urandom_range(1);
            rd         = 5'($urandom);
            br_type    = 2'($urandom);
            cond       = 4'($urandom);
            flush      = $urandom_range(15) == 0;
            out_ready  = $urandom_range(2) != 0;
            reset      = $urandom_range(99) != 0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-low; sampled only on rising clk.
REQ-003 SHALL have: in_valid  in  1  upstream ALU transaction present.
REQ-004 SHALL have: in_ready  out  1  stage can accept this cycle.
REQ-005 SHALL have: alu_result  in  64  ALU result; alu_n, alu_z, alu_v, alu_c  in  1 each  ALU flags.
REQ-006 SHALL have: set_flags  in  1  commit NZVC on accept; reg_write  in  1; rd  in  5  destination register.
REQ-007 SHALL have: br_type  in  2  00 none, 01 CBZ, 10 CBNZ, 11 B.cond; cond  in  4  B.cond code.
REQ-008 SHALL have: flush  in  1  kill held and incoming transaction.
REQ-009 SHALL have: out_valid  out  1; out_ready  in  1  downstream handshake.
REQ-010 SHALL have: out_result  out  64; out_rd  out  5; out_reg_write  out  1; out_br_taken  out  1.
REQ-011 SHALL have: flags  out  4  committed {N,Z,V,C}; taken_cnt  out  16  taken-branch count.

Function
REQ-012 SHALL hold one output entry; in_ready = !out_valid | out_ready (combinational, no flush term).
REQ-013 SHALL accept when in_valid & in_ready & !flush; entry loads next edge; latency 1 cycle in to out.
REQ-014 SHALL hold out_* stable while out_valid & !out_ready.
REQ-015 SHALL clear out_valid on edge where out_ready & out_valid & no accept; accept + drain same cycle loads new entry, out_valid stays 1.
REQ-016 SHALL on accept with set_flags load flags <= {alu_n,alu_z,alu_v,alu_c}; otherwise flags unchanged.
REQ-017 CBZ: taken = alu_z; CBNZ: taken = !alu_z (ALU passes operand through).
REQ-018 B.cond SHALL evaluate the committed flags register before this transaction's own update: EQ 0000 Z; NE 0001 !Z; HS 0010 C; LO 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V; HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V); 1110 and 1111 always.
REQ-019 br_type 00 SHALL give out_br_taken 0; taken value registered with entry.
REQ-020 taken_cnt SHALL increment by 1 on each accept with computed taken=1, wrapping 0xFFFF -> 0x0000.
REQ-021 flush SHALL on next edge clear out_valid, block accept, and leave flags and taken_cnt unchanged that cycle.
REQ-022 Back-to-back set_flags then B.cond SHALL see flags from the first (already committed at accept edge).
REQ-023 out_reg_write SHALL be qualified: downstream may treat it as meaningful only when out_valid=1.

Reset
REQ-024 reset=0 at edge SHALL set out_valid 0, out_result 0, out_rd 0, out_reg_write 0, out_br_taken 0, flags 4'b0000, taken_cnt 0.
REQ-025 reset SHALL take priority over flush, accept and drain; in_ready during reset follows REQ-012 from cleared state (=1).
REQ-026 reset mid-transaction SHALL discard held entry with no flag or counter side effect.

Verification
REQ-027 Pass-through: in_valid=1, alu_result=0x0000_0000_0000_002A, rd=5, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_result=0x2A, out_rd=5; following idle cycle out_valid=0.
REQ-028 Backpressure: hold out_ready=0 with entry A valid, present B -> in_ready=0, out_* = A unchanged 3 cycles; raise out_ready -> B loads next edge, out_valid stays 1.
REQ-029 Flags/B.cond: accept set_flags with N=1,Z=0,V=0,C=0 -> flags=4'b1000; next B.cond cond=1011 (LT) -> out_br_taken=1, taken_cnt=1; cond=1010 (GE) -> taken 0.
REQ-030 CBZ/CBNZ: alu_z=1 br_type=01 -> taken 1; alu_z=1 br_type=10 -> taken 0; flags unchanged when set_flags=0.
REQ-031 Flush/wrap: preload taken_cnt 0xFFFF via taken branches, one more -> 0x0000; flush with in_valid=1 set_flags=1 -> out_valid 0, flags and taken_cnt unchanged.
REQ-032 Reset mid-op: reset=0 while out_valid=1, out_ready=0 -> next edge all outputs per REQ-024, in_ready=1.
